// File: rtl/freq_meter.sv
// Zero-crossing frequency meter: hysteretic comparator, NPER-period sample
// counter and a restoring divider that turns the window length into an NCO word.

module freq_meter_div #(
    parameter int NPER = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        abort,
    input  logic [31:0] dvsr_in,
    output logic        busy,
    output logic        done,
    output logic [27:0] q
);
    logic [31:0] rem;
    logic [31:0] dvsr;
    logic [32:0] rem2;
    logic [31:0] rem_sub;
    logic [27:0] qr;
    logic [4:0]  cnt;
    logic        sat;
    logic        ge;

    // Dividend is NPER * 2**28: the high part NPER seeds the remainder and the
    // 28 low zero bits are shifted in, one quotient bit per cycle.
    assign rem2    = {rem, 1'b0};
    assign ge      = rem2 >= {1'b0, dvsr};
    assign rem_sub = rem2[31:0] - dvsr;
    assign done    = busy && (cnt == 5'd29);
    assign q       = sat ? 28'hFFF_FFFF : qr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy <= 1'b0;
            cnt  <= '0;
            rem  <= '0;
            dvsr <= '0;
            qr   <= '0;
            sat  <= 1'b0;
        end else if (abort) begin
            busy <= 1'b0;
        end else if (start) begin
            busy <= 1'b1;
            cnt  <= '0;
            rem  <= 32'(NPER);
            dvsr <= dvsr_in;
            qr   <= '0;
            // quotient reaches 2**28 exactly when T <= NPER
            sat  <= dvsr_in <= 32'(NPER);
        end else if (busy) begin
            if (cnt < 5'd28) begin
                rem <= ge ? rem_sub : rem2[31:0];
                qr  <= {qr[26:0], ge};
            end
            cnt <= cnt + 5'd1;
            if (done)
                busy <= 1'b0;
        end
    end
endmodule

module freq_meter #(
    parameter int NPER    = 16,
    parameter int HYST    = 1024,
    parameter int PER_MAX = 2**20
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic signed [15:0] in,
    input  logic               in_valid,
    output logic [27:0]        freq,
    output logic               freq_valid,
    output logic               no_sig
);
    localparam int LN = $clog2(NPER);
    localparam int CW = $clog2(PER_MAX + 1);
    localparam logic signed [15:0] HPOS = 16'(HYST);
    localparam logic signed [15:0] HNEG = 16'(-HYST);

    typedef enum logic {IDLE, MEAS} state_t;

    state_t      st;
    logic        lvl;
    logic [31:0] pcnt;
    logic [CW-1:0] ccnt;
    logic [LN-1:0] k;

    logic        pos, neg, rise, tmo, close;
    logic        dv_busy, dv_done;
    logic [27:0] dv_q;

    assign pos   = in_valid && (in >= HPOS);
    assign neg   = in_valid && (in <= HNEG);
    assign rise  = pos && !lvl;
    // a crossing on the same sample pre-empts the timeout
    assign tmo   = in_valid && (st == MEAS) && !rise && (ccnt == CW'(PER_MAX));
    assign close = (st == MEAS) && rise && (k == LN'(NPER - 1));

    freq_meter_div #(.NPER(NPER)) u_div (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (close),
        .abort   (tmo),
        .dvsr_in (pcnt),
        .busy    (dv_busy),
        .done    (dv_done),
        .q       (dv_q)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st         <= IDLE;
            lvl        <= 1'b0;
            pcnt       <= '0;
            ccnt       <= '0;
            k          <= '0;
            freq       <= '0;
            freq_valid <= 1'b0;
            no_sig     <= 1'b1;
        end else begin
            freq_valid <= 1'b0;
            if (pos)
                lvl <= 1'b1;
            else if (neg)
                lvl <= 1'b0;

            case (st)
                IDLE: begin
                    if (rise) begin
                        pcnt <= 32'd1;
                        ccnt <= CW'(1);
                        k    <= '0;
                        st   <= MEAS;
                    end
                end
                MEAS: begin
                    if (tmo) begin
                        st         <= IDLE;
                        pcnt       <= '0;
                        ccnt       <= '0;
                        k          <= '0;
                        freq       <= '0;
                        freq_valid <= 1'b1;
                        no_sig     <= 1'b1;
                    end else if (rise) begin
                        ccnt <= CW'(1);
                        if (close) begin
                            pcnt <= 32'd1;
                            k    <= '0;
                        end else begin
                            pcnt <= pcnt + 32'd1;
                            k    <= k + LN'(1);
                        end
                    end else if (in_valid) begin
                        pcnt <= pcnt + 32'd1;
                        ccnt <= ccnt + CW'(1);
                    end
                end
                default: st <= IDLE;
            endcase

            if (dv_done && !tmo) begin
                freq       <= dv_q;
                freq_valid <= 1'b1;
                no_sig     <= 1'b0;
            end
        end
    end

    // window length guarantees the divider has finished before the next close
    a_no_overrun: assert property (@(posedge clk) disable iff (!rst_n) !(close && dv_busy));
endmodule

// File: tb/tb_freq_meter.sv
// Directed bench for freq_meter: square-wave tones, loss of signal, hysteresis,
// reset mid-division, and a direct table sweep of the divider.

module tb_freq_meter;
    localparam int PER_MAX = 600;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic signed [15:0] in = '0;
    logic               in_valid = 1'b0;
    logic [27:0]        freq;
    logic               freq_valid;
    logic               no_sig;

    logic               d_start = 1'b0;
    logic [31:0]        d_dvsr = '0;
    logic               d_busy, d_done;
    logic [27:0]        d_q;

    freq_meter #(.NPER(16), .HYST(1024), .PER_MAX(PER_MAX)) dut (
        .clk(clk), .rst_n(rst_n), .in(in), .in_valid(in_valid),
        .freq(freq), .freq_valid(freq_valid), .no_sig(no_sig)
    );

    freq_meter_div #(.NPER(16)) udiv (
        .clk(clk), .rst_n(rst_n), .start(d_start), .abort(1'b0),
        .dvsr_in(d_dvsr), .busy(d_busy), .done(d_done), .q(d_q)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk = 0, n_fail = 0;
    int gen_mode = 0, gen_per = 64, ph = 0, cur = 0;
    bit gen_gate = 0, gtog = 0, htog = 0, ns_prev = 1;
    int rise_q[$];
    int pe_q[$], pf_q[$], pn_q[$], pp_q[$];

    typedef struct {
        logic [31:0] t;
        logic [27:0] q;
    } dvec_t;
    dvec_t vt[8];

    // stimulus: mode 0 idle, 1 square tone, 2 zeros, 3 +/-1000 toggle
    initial forever begin
        @(posedge clk); #1;
        gtog = ~gtog;
        if (gen_mode == 0) begin
            in_valid = 1'b0;
            in = '0;
        end else if (gen_gate && gtog) begin
            in_valid = 1'b0;
            in = 16'(-cur);
        end else begin
            if (gen_mode == 1) begin
                cur = (ph < gen_per / 2) ? -20000 : 20000;
                if (ph == gen_per / 2) rise_q.push_back(cyc + 1);
                ph = (ph + 1) % gen_per;
            end else if (gen_mode == 2) begin
                cur = 0;
            end else begin
                htog = ~htog;
                cur = htog ? 1000 : -1000;
            end
            in_valid = 1'b1;
            in = 16'(cur);
        end
    end

    initial forever begin
        @(posedge clk); #2;
        if (freq_valid) begin
            pe_q.push_back(cyc);
            pf_q.push_back(int'(freq));
            pn_q.push_back(int'(no_sig));
            pp_q.push_back(int'(ns_prev));
        end
        ns_prev = no_sig;
    end

    function automatic int pe(input int i); return (i < pe_q.size()) ? pe_q[i] : -1; endfunction
    function automatic int pf(input int i); return (i < pf_q.size()) ? pf_q[i] : -1; endfunction
    function automatic int pn(input int i); return (i < pn_q.size()) ? pn_q[i] : -1; endfunction
    function automatic int pp(input int i); return (i < pp_q.size()) ? pp_q[i] : -1; endfunction
    function automatic int rq(input int i); return (i < rise_q.size()) ? rise_q[i] : -1000; endfunction

    task automatic chk(input string nm, input longint act, input longint exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic clr();
        rise_q.delete(); pe_q.delete(); pf_q.delete(); pn_q.delete(); pp_q.delete();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        gen_mode = 0;
        gen_gate = 0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        ph = 0;
        clr();
    endtask

    task automatic wait_pulses(input int n, input int bound, input string nm);
        int c = 0;
        while (pe_q.size() < n && c < bound) begin
            @(negedge clk);
            c++;
        end
        chk({nm, " pulses seen"}, pe_q.size() >= n, 1);
    endtask

    initial begin
        int r, lat, c;
        vt[0] = '{32'd16,         28'd268435455};
        vt[1] = '{32'd1,          28'd268435455};
        vt[2] = '{32'd32,         28'd134217728};
        vt[3] = '{32'd17,         28'd252645135};
        vt[4] = '{32'd1024,       28'd4194304};
        vt[5] = '{32'd4096,       28'd1048576};
        vt[6] = '{32'd12345,      28'd347911};
        vt[7] = '{32'hFFFF_FFFF,  28'd1};

        // reset state
        repeat (3) @(negedge clk);
        chk("reset freq", freq, 0);
        chk("reset freq_valid", freq_valid, 0);
        chk("reset no_sig", no_sig, 1);

        // 64 samples/cycle tone
        do_reset();
        gen_per = 64; gen_mode = 1;
        wait_pulses(3, 5000, "tone64");
        chk("tone64 first pulse edge", pe(0), rq(16) + 30);
        chk("tone64 spacing 1", pe(1) - pe(0), 1024);
        chk("tone64 spacing 2", pe(2) - pe(1), 1024);
        for (int i = 0; i < 3; i++) chk("tone64 freq", pf(i), 4194304);
        chk("tone64 no_sig before", pp(0), 1);
        chk("tone64 no_sig after", pn(0), 0);

        // loss of signal
        gen_mode = 2;
        r = rq(rise_q.size() - 1);
        pe_q.delete(); pf_q.delete(); pn_q.delete(); pp_q.delete();
        repeat (PER_MAX + 200) @(negedge clk);
        chk("loss pulse count", pe_q.size(), 1);
        chk("loss pulse edge", pe(0), r + PER_MAX);
        chk("loss freq", pf(0), 0);
        chk("loss no_sig", pn(0), 1);
        repeat (2 * PER_MAX) @(negedge clk);
        chk("loss no further pulses", pe_q.size(), 1);
        clr(); ph = 0; gen_mode = 1;
        wait_pulses(1, 2000, "relock");
        chk("relock first pulse edge", pe(0), rq(16) + 30);
        chk("relock freq", pf(0), 4194304);

        // 256 samples/cycle, in_valid gated 50%
        do_reset();
        gen_per = 256; gen_gate = 1; gen_mode = 1;
        wait_pulses(2, 20000, "gated");
        chk("gated first pulse edge", pe(0), rq(16) + 30);
        chk("gated spacing", pe(1) - pe(0), 8192);
        chk("gated freq 0", pf(0), 1048576);
        chk("gated freq 1", pf(1), 1048576);
        gen_gate = 0;

        // hysteresis: +/-1000 never crosses
        do_reset();
        gen_mode = 3;
        repeat (2000) @(negedge clk);
        chk("hyst pulses", pe_q.size(), 0);
        chk("hyst freq", freq, 0);
        chk("hyst no_sig", no_sig, 1);

        // reset 10 cycles after T latched, with a prior result held
        do_reset();
        gen_per = 64; gen_mode = 1;
        c = 0;
        while (rise_q.size() < 33 && c < 3000) begin @(negedge clk); c++; end
        chk("rstmid crossings seen", rise_q.size() >= 33, 1);
        c = 0;
        while (cyc < rq(32) + 10 && c < 3000) begin @(negedge clk); c++; end
        chk("rstmid freq before", freq, 4194304);
        rst_n = 1'b0;
        gen_mode = 0;
        #1;
        chk("rstmid freq", freq, 0);
        chk("rstmid freq_valid", freq_valid, 0);
        chk("rstmid no_sig", no_sig, 1);
        pe_q.delete();
        repeat (40) @(negedge clk);
        chk("rstmid pulses during reset", pe_q.size(), 0);
        rst_n = 1'b1;
        clr(); ph = 0; gen_mode = 1;
        wait_pulses(1, 2000, "rstmid");
        chk("rstmid first pulse edge", pe(0), rq(16) + 30);
        chk("rstmid freq after", pf(0), 4194304);

        // period-2 square wave: T=32
        do_reset();
        gen_per = 2; gen_mode = 1;
        wait_pulses(1, 300, "sq2");
        chk("sq2 freq", pf(0), 134217728);
        chk("sq2 no_sig", pn(0), 0);
        gen_mode = 0;

        // divider driven directly, including T below the saturation limit
        foreach (vt[i]) begin
            @(negedge clk);
            d_dvsr = vt[i].t;
            d_start = 1'b1;
            @(negedge clk);
            d_start = 1'b0;
            lat = 1;
            while (!d_done && lat < 40) begin @(negedge clk); lat++; end
            chk($sformatf("div latency T=%0d", vt[i].t), lat, 30);
            chk($sformatf("div q T=%0d", vt[i].t), d_q, vt[i].q);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/freq_meter.md
# freq_meter

Zero-crossing frequency meter that turns a signed 16-bit sinusoid back into a 28-bit phase-increment word. The word uses the same scaling as our NCO frequency input, so a tone synthesised with word F measures as F. It sits on the loopback/monitor path after the NCO or DSM reconstruction filter, and feeds status registers and closed-loop frequency checks. Period is measured over NPER cycles with hysteresis, and the frequency word is formed by an iterative divider.

## Interface
- NPER, 16: input cycles averaged per measurement. Must be a power of 2 and ≥16.
- HYST, 1024: hysteresis threshold on the input, in LSB, positive.
- PER_MAX, 2**20: maximum samples allowed between rising crossings before the input is declared lost. NPER*PER_MAX must be ≤ 2**32.
- clk  in  1  clock, sole clock domain.
- rst_n  in  1  asynchronous active-low reset. Asserts asynchronously; deassertion is synchronised externally.
- in  in  16  signed input sample.
- in_valid  in  1  qualifies `in`. Only qualified samples are counted or compared.
- freq  out  28  last measured frequency word. Holds between updates.
- freq_valid  out  1  one-cycle pulse when `freq` updates.
- no_sig  out  1  level; 1 while no valid measurement is available.

## Operation
- **Comparator**
  - One-bit state lvl, reset to NEG.
  - On each valid sample: lvl goes to POS when in ≥ +HYST, and to NEG when in ≤ −HYST. Otherwise lvl holds.
  - A NEG→POS change is a rising crossing.
- **Sample counter**
  - pcnt, 32 bits: valid samples since the last window-closing crossing.
  - ccnt: samples since the last crossing, used for the timeout.
  - The crossing sample itself is counted as the first sample of the new window.
- **State machine**
  - IDLE: wait for the first rising crossing. On it, pcnt=1, ccnt=1, crossing count k=0, then go to MEAS.
  - MEAS: increment pcnt and ccnt on each valid sample. On each rising crossing, set k=k+1 and ccnt=1. When k reaches NPER:
    - latch T=pcnt (including pre-increment of the closing sample; T counts exactly the samples in NPER periods),
    - restart pcnt=1 and k=0,
    - start the divider, and remain in MEAS.
  - Timeout: if ccnt would exceed PER_MAX in any state other than IDLE, do all of the following and go to IDLE:
    - set freq=0,
    - pulse freq_valid,
    - set no_sig=1,
    - abort any division in progress with no result.
- **Divider**
  - Computes q = floor(2**(28+log2 NPER) / T), restoring, one quotient bit per cycle.
  - If q ≥ 2**28, the result saturates to 2**28−1.
  - On completion: freq=q, freq_valid=1 for one cycle, no_sig=0.
- **Overlap**
  - A window is never shorter than 2*NPER ≥ 32 samples, so the divider is always idle when T is latched.
  - No overrun handling is required. Assert this in simulation.
- **Reset values:** freq=0, freq_valid=0, no_sig=1, state IDLE, lvl NEG, all counters 0.

## Timing
- The comparator and crossing detection act on the sample accepted in cycle n. State and counters update at the clk edge ending cycle n.
- Divider latency is fixed: freq and freq_valid change at the clk edge 30 cycles after the edge that latched T. This holds independent of in_valid.
- A timeout takes effect at the edge that accepts the sample that would make ccnt = PER_MAX+1. freq_valid pulses on the same edge.
- When timeout and a rising crossing occur on the same sample, the crossing wins: no timeout.
- Samples with in_valid=0 are ignored entirely: no counting, no comparing, no timeout progress.
- The divider runs every cycle regardless of in_valid.
- rst_n low at any time, including mid-division, forces reset values immediately. No freq_valid pulse is produced for the aborted work.
- Outputs are registered; there is no combinational path from in/in_valid to any output.

## Test plan
- **Exact tone, 64 samples/cycle:** NCO freq=2**22, in_valid=1 constantly. Required: T=1024 and freq=4194304 on every freq_valid. Consecutive pulses are 1024 cycles apart, the first occurring 30 cycles after the 17th rising crossing. no_sig falls with the first pulse.
- **Exact tone, 256 samples/cycle, in_valid gated 50%:** freq=2**20 with in_valid alternating. Required: freq=1048576 and pulse spacing 8192 cycles, identical to ungated operation.
- **Loss of signal:** lock at 2**22, then force in=0. Required: exactly PER_MAX+1 valid samples after the last crossing, freq=0, one freq_valid pulse, no_sig=1, state IDLE, and no further pulses until the tone returns.
- **Hysteresis:** in toggling between +1000 and −1000 every sample. Required: no crossings detected, freq stays 0, no_sig stays 1, and a timeout never fires from IDLE.
- **Reset mid-operation:** drop rst_n 10 cycles after T is latched. Required: outputs return to reset values immediately, and no freq_valid pulse occurs. After release with the 2**22 tone, the first result appears only after a full NPER-cycle window plus 30 cycles.
- **Saturation:** square wave ±20000 with period 2 samples and NPER=16. Required: T=32, giving q=2**27=134217728, which is not saturated. Forcing T=16 through a bench-only override must produce 268435455.
